// File: rtl/gcd_controller.sv
// gcd_controller: valid/ready operand loader and subtract-loop FSM for the GCD datapath (optional GCD_ZERO_CHECK_EN)
module gcd_controller #(
  parameter int MAX_ITER = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data_in,
  input  logic       lt,
  input  logic       gt,
  input  logic       eq,
  output logic       lda,
  output logic       ldb,
  output logic       sela,
  output logic       selb,
  output logic       sel_in,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int CW = $clog2(MAX_ITER + 1);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, DONE, ERR} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic timeout, load_in, step, zero_hit;
  assign timeout  = cnt == CW'(MAX_ITER);
  assign load_in  = state == LOAD_A || state == LOAD_B;
  assign step     = state == CALC && !eq && !timeout;
  assign in_ready = load_in;
  assign sel_in   = load_in;
  assign lda      = (state == LOAD_A && in_valid) || (step && gt);
  assign ldb      = (state == LOAD_B && in_valid) || (step && lt && !gt);
  assign sela     = lda && !sel_in;
  assign selb     = ldb && !sel_in;
`ifdef GCD_ZERO_CHECK_EN
  logic zero_flag;
  assign zero_hit = zero_flag || (in_valid && data_in == 8'd0);
  // remember any zero operand accepted since leaving IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) zero_flag <= 1'b0;
    else zero_flag <= state == IDLE ? 1'b0 : zero_flag || (load_in && in_valid && data_in == 8'd0);
`else
  logic unused_data;
  assign unused_data = ^data_in;
  assign zero_hit = 1'b0;
`endif
  // state transitions, iteration counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD_A;
          busy  <= 1'b1;
        end
        LOAD_A: if (in_valid) state <= LOAD_B;
        LOAD_B: if (in_valid) begin
          cnt   <= '0;
          state <= zero_hit ? ERR : CALC;
          err   <= zero_hit;
        end
        CALC: if (eq) begin
          state <= DONE;
          done  <= 1'b1;
        end else if (timeout) begin
          state <= ERR;
          err   <= 1'b1;
        end else if (gt || lt) cnt <= cnt + 1'b1;
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
Control FSM for the 8-bit subtract-based GCD datapath. Accepts two operands over a valid/ready handshake and steers them into the datapath registers via the shared data_in bus. Iterates subtract steps using the datapath's lt/gt/eq flags, then signals completion, or signals an error on timeout. Sits directly upstream of the datapath and drives every one of its control inputs.

Parameters:
MAX_ITER, 255, maximum subtract cycles per computation before timeout error; must be >= 1. Iteration counter width = $clog2(MAX_ITER+1).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin a computation; sampled only in IDLE
in_valid  input  1  operand word present on the datapath's data_in bus
in_ready  output  1  controller accepts operand word this cycle
data_in  input  8  operand word, monitored only by the optional zero check; the datapath receives it directly
lt  input  1  datapath a<b
gt  input  1  datapath a>b
eq  input  1  datapath a==b
lda  output  1  datapath load enable, register a
ldb  output  1  datapath load enable, register b
sela  output  1  datapath a-source select; equals lda && !sel_in
selb  output  1  datapath b-source select; equals ldb && !sel_in
sel_in  output  1  1 = load from data_in, 0 = load subtraction result
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: result valid on datapath aout/bout
err  output  1  one-cycle pulse: computation aborted

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, iteration counter=0. All outputs 0. Takes effect mid-computation too; the datapath contents are then don't-care.
- States: IDLE, LOAD_A, LOAD_B, CALC, DONE, ERR.
- IDLE: start=1 -> LOAD_A. Otherwise stay.
- LOAD_A: in_ready=1, sel_in=1. If in_valid: lda=1, go to LOAD_B. Otherwise wait indefinitely.
- LOAD_B: in_ready=1, sel_in=1. If in_valid: ldb=1, clear the counter, go to CALC.
- lda, ldb, sel_in, sela, selb and in_ready are combinational from state and inputs. busy, done and err are registered outputs.
- CALC (flags reflect the registered a and b):
  - eq -> DONE, no load.
  - gt -> lda=1, sel_in=0, so a <= a-b.
  - lt -> ldb=1, sel_in=0, so b <= b-a.
  - Each gt or lt cycle increments the counter.
  - If the counter equals MAX_ITER and eq=0 -> ERR, with no load that cycle.
  - eq has priority over the timeout check.
- DONE: done=1 for one cycle -> IDLE. The result is held in the datapath registers until the next load.
- ERR: err=1 for one cycle -> IDLE.
- start outside IDLE is ignored. in_valid outside LOAD_A/LOAD_B is ignored, with in_ready=0.
- start and in_valid both high in IDLE: only the state transition happens; the operand is accepted in the next cycle if in_valid is still high.
- Latency with in_valid held high: start cycle, +1 LOAD_A, +1 LOAD_B, +N subtract cycles in CALC, +1 CALC eq cycle, then done in the following cycle. Total: done is high N+4 cycles after the start cycle.
- Operand 0 without the optional feature: the loop never reaches eq, so the computation ends in ERR via timeout. The exception is (0,0), where eq=1 and done fires with result 0.

Optional Feature:
Macro GCD_ZERO_CHECK_EN.
- Defined:
  - Controller registers a flag when an accepted data_in word equals 0, in either LOAD_A or LOAD_B.
  - On leaving LOAD_B with the flag set: go straight to ERR, skip CALC, issue no subtract loads.
  - The flag clears in IDLE.
- Undefined: no flag, and zero operands behave as described above under Behaviour.

Test Plan:
- (48,18), in_valid held high -> 4 subtract cycles (30/18, 12/18, 12/6, 6/6); done pulses 8 cycles after start; aout=bout=6; err never asserts.
- (7,7) -> zero subtracts; done pulses 4 cycles after start; lda and ldb low throughout CALC.
- MAX_ITER=8, (200,1) -> exactly 8 lda pulses with sel_in=0; err pulses; done stays 0; busy drops the same cycle the controller returns to IDLE.
- (0,5) with GCD_ZERO_CHECK_EN -> err in the cycle after LOAD_B and no subtract loads. Without the macro -> err after MAX_ITER cycles.
- in_valid stalled 3 cycles in LOAD_A and 2 cycles in LOAD_B -> in_ready stays high, no loads while stalled; start pulses during CALC are ignored; final result of (21,14) is 7.
- rst_n asserted low mid-CALC -> all outputs 0 immediately. After release, a new start with (9,6) completes with done and result 3.
